hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core.
- Generates the per-stage `stall_*` / `bubble_*` controls consumed by the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, plus the PC-redirect select.
- Resolves load-use hazards, EX-stage branch/jump redirects, and multi-cycle instruction/data memory waits.
- Owns a small FSM and target latch so a redirect arriving while an instruction fetch cannot be cancelled is deferred and applied when the fetch completes.

---
 rtl/hazard_ctrl_if.sv | 56 +++++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs, memory handshakes, and the
// per-stage stall/bubble/redirect controls plus performance counters.
interface hazard_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 32;

    logic [RW-1:0]   rs1_id;
    logic [RW-1:0]   rs2_id;
    logic            rs1_used_id;
    logic            rs2_used_id;
    logic [RW-1:0]   rd_ex;
    logic            mem_read_ex;
    logic            redirect_ex;
    logic [XLEN-1:0] redirect_target_ex;
    logic            imem_req;
    logic            imem_ready;
    logic            dmem_req_mem;
    logic            dmem_ready;

    logic            stall_if;
    logic            stall_id;
    logic            stall_ex;
    logic            stall_mem;
    logic            bubble_id;
    logic            bubble_ex;
    logic            bubble_mem;
    logic            bubble_wb;
    logic            pc_redirect;
    logic [XLEN-1:0] pc_redirect_target;
    logic [CW-1:0]   perf_stall_cycles;
    logic [CW-1:0]   perf_flush_count;

    // Pipeline side: drives hazard sources, consumes controls.
    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
               redirect_ex, redirect_target_ex, imem_req, imem_ready,
               dmem_req_mem, dmem_ready,
        input  stall_if, stall_id, stall_ex, stall_mem,
               bubble_id, bubble_ex, bubble_mem, bubble_wb,
               pc_redirect, pc_redirect_target,
               perf_stall_cycles, perf_flush_count
    );

    // Controller side.
    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, mem_read_ex,
               redirect_ex, redirect_target_ex, imem_req, imem_ready,
               dmem_req_mem, dmem_ready,
        output stall_if, stall_id, stall_ex, stall_mem,
               bubble_id, bubble_ex, bubble_mem, bubble_wb,
               pc_redirect, pc_redirect_target,
               perf_stall_cycles, perf_flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX redirects (deferred while a
// fetch is in flight) and memory-wait freezes. Perf counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic          clk,
    input  logic          rstn,
    hazard_ctrl_if.slave  hz
);
    localparam int unsigned CW = 32;

    typedef enum logic {
        RUN  = 1'b0,
        KILL = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] tgt_q;
    logic            tgt_load_c;

    logic mem_busy_c;
    logic if_busy_c;
    logic load_use_c;

    assign mem_busy_c = hz.dmem_req_mem & ~hz.dmem_ready;
    assign if_busy_c  = hz.imem_req & ~hz.imem_ready;
    assign load_use_c = hz.mem_read_ex & (hz.rd_ex != 5'd0) &
                        ((hz.rs1_used_id & (hz.rs1_id == hz.rd_ex)) |
                         (hz.rs2_used_id & (hz.rs2_id == hz.rd_ex)));

    // State and deferred-target register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (tgt_load_c) begin
                tgt_q <= hz.redirect_target_ex;
            end
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d               = state_q;
        tgt_load_c            = 1'b0;
        hz.stall_if           = 1'b0;
        hz.stall_id           = 1'b0;
        hz.stall_ex           = 1'b0;
        hz.stall_mem          = 1'b0;
        hz.bubble_id          = 1'b0;
        hz.bubble_ex          = 1'b0;
        hz.bubble_mem         = 1'b0;
        hz.bubble_wb          = 1'b0;
        hz.pc_redirect        = 1'b0;
        hz.pc_redirect_target = hz.redirect_target_ex;

        unique case (state_q)
            RUN: begin
                if (mem_busy_c) begin
                    hz.stall_if  = 1'b1;
                    hz.stall_id  = 1'b1;
                    hz.stall_ex  = 1'b1;
                    hz.stall_mem = 1'b1;
                    hz.bubble_wb = 1'b1;
                end else if (hz.redirect_ex && !if_busy_c) begin
                    hz.pc_redirect = 1'b1;
                    hz.bubble_id   = 1'b1;
                    hz.bubble_ex   = 1'b1;
                end else if (hz.redirect_ex) begin
                    // Fetch cannot be cancelled: park the target until it lands.
                    hz.stall_if  = 1'b1;
                    hz.bubble_id = 1'b1;
                    hz.bubble_ex = 1'b1;
                    tgt_load_c   = 1'b1;
                    state_d      = KILL;
                end else if (load_use_c) begin
                    hz.stall_if  = 1'b1;
                    hz.stall_id  = 1'b1;
                    hz.bubble_ex = 1'b1;
                end else if (if_busy_c) begin
                    hz.stall_if  = 1'b1;
                    hz.bubble_id = 1'b1;
                end
            end
            KILL: begin
                hz.pc_redirect_target = tgt_q;
                if (mem_busy_c) begin
                    hz.stall_if  = 1'b1;
                    hz.stall_id  = 1'b1;
                    hz.stall_ex  = 1'b1;
                    hz.stall_mem = 1'b1;
                    hz.bubble_wb = 1'b1;
                end else if (if_busy_c) begin
                    hz.stall_if  = 1'b1;
                    hz.bubble_id = 1'b1;
                end else begin
                    // Wrong-path instruction arrives now; drop it and redirect.
                    hz.pc_redirect = 1'b1;
                    hz.bubble_id   = 1'b1;
                    state_d        = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cnt_q;
    logic [CW-1:0] flush_cnt_q;

    // Wrapping stall / flush counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hz.stall_if) begin
                stall_cnt_q <= stall_cnt_q + CW'(1);
            end
            if (hz.pc_redirect && !hz.stall_if) begin
                flush_cnt_q <= flush_cnt_q + CW'(1);
            end
        end
    end

    assign hz.perf_stall_cycles = stall_cnt_q;
    assign hz.perf_flush_count  = flush_cnt_q;
`else
    assign hz.perf_stall_cycles = '0;
    assign hz.perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;
    localparam int unsigned XLEN = 32;

    // {stall_if, stall_id, stall_ex, stall_mem, bubble_id, bubble_ex, bubble_mem, bubble_wb, pc_redirect}
    localparam logic [8:0] C_NONE   = 9'b0000_0000_0;
    localparam logic [8:0] C_FREEZE = 9'b1111_0001_0;
    localparam logic [8:0] C_REDIR  = 9'b0000_1100_1;
    localparam logic [8:0] C_DEFER  = 9'b1000_1100_0;
    localparam logic [8:0] C_LU     = 9'b1100_0100_0;
    localparam logic [8:0] C_IFW    = 9'b1000_1000_0;
    localparam logic [8:0] C_KDONE  = 9'b0000_1000_1;

    logic clk;
    logic rstn;
    int   errors;
    int   checks;

    hazard_ctrl_if #(.XLEN(XLEN)) hz ();

    hazard_ctrl #(.XLEN(XLEN)) dut (
        .clk  (clk),
        .rstn (rstn),
        .hz   (hz)
    );

    logic [8:0] ctl;
    assign ctl = {hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem,
                  hz.bubble_id, hz.bubble_ex, hz.bubble_mem, hz.bubble_wb,
                  hz.pc_redirect};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        hz.rs1_id             = 5'd0;
        hz.rs2_id             = 5'd0;
        hz.rs1_used_id        = 1'b0;
        hz.rs2_used_id        = 1'b0;
        hz.rd_ex              = 5'd0;
        hz.mem_read_ex        = 1'b0;
        hz.redirect_ex        = 1'b0;
        hz.redirect_target_ex = 32'h0;
        hz.imem_req           = 1'b1;
        hz.imem_ready         = 1'b1;
        hz.dmem_req_mem       = 1'b0;
        hz.dmem_ready         = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1-2 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        #2;
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        hz.redirect_target_ex = 32'h55;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (ctl !== C_NONE) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=%b", ctl, C_NONE);
        end
        checks++;
        if (hz.pc_redirect_target !== 32'h55) begin
            errors++;
            $display("FAIL reset_target got=%h exp=%h", hz.pc_redirect_target, 32'h55);
        end
        checks++;
        if (hz.perf_stall_cycles !== 32'd0 || hz.perf_flush_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf got=%0d/%0d exp=0/0", hz.perf_stall_cycles, hz.perf_flush_count);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        logic [8:0] exp_ctl [4];
        // rs1 hit, rs2 hit, rd=0, rs1 match but not used
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            hz.mem_read_ex = 1'b1;
            hz.rs1_used_id = (i != 3) && (i != 1);
            hz.rs2_used_id = (i == 1);
            hz.rd_ex       = (i == 2) ? 5'd0 : 5'd5;
            hz.rs1_id      = (i == 1) ? 5'd7 : ((i == 2) ? 5'd0 : 5'd5);
            hz.rs2_id      = (i == 1) ? 5'd5 : 5'd9;
            exp_ctl[i]     = (i < 2) ? C_LU : C_NONE;
            #1;
            checks++;
            if (ctl !== exp_ctl[i]) begin
                errors++;
                $display("FAIL load_use_%0d got=%b exp=%b", i, ctl, exp_ctl[i]);
            end
            tick();
            // Load has moved on; EX now holds the inserted bubble.
            idle_inputs();
            #1;
            checks++;
            if (ctl !== C_NONE) begin
                errors++;
                $display("FAIL load_use_after_%0d got=%b exp=%b", i, ctl, C_NONE);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        idle_inputs();
        hz.redirect_ex        = 1'b1;
        hz.redirect_target_ex = 32'h100;
        #1;
        checks++;
        if (ctl !== C_REDIR) begin
            errors++;
            $display("FAIL branch_ctl got=%b exp=%b", ctl, C_REDIR);
        end
        checks++;
        if (hz.pc_redirect_target !== 32'h100) begin
            errors++;
            $display("FAIL branch_target got=%h exp=%h", hz.pc_redirect_target, 32'h100);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ctl !== C_NONE) begin
            errors++;
            $display("FAIL branch_after got=%b exp=%b", ctl, C_NONE);
        end
        tick();
    endtask

    task automatic test_deferred();
        idle_inputs();
        hz.redirect_ex        = 1'b1;
        hz.redirect_target_ex = 32'h200;
        hz.imem_ready         = 1'b0;
        #1;
        checks++;
        if (ctl !== C_DEFER) begin
            errors++;
            $display("FAIL defer_enter got=%b exp=%b", ctl, C_DEFER);
        end
        tick();
        // In KILL: redirect and load-use inputs must be ignored.
        hz.redirect_ex        = 1'b0;
        hz.redirect_target_ex = 32'hDEAD;
        hz.mem_read_ex        = 1'b1;
        hz.rd_ex              = 5'd3;
        hz.rs1_id             = 5'd3;
        hz.rs1_used_id        = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (ctl !== C_IFW) begin
                errors++;
                $display("FAIL defer_wait_%0d got=%b exp=%b", i, ctl, C_IFW);
            end
            tick();
        end
        hz.imem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== C_KDONE) begin
            errors++;
            $display("FAIL defer_done got=%b exp=%b", ctl, C_KDONE);
        end
        checks++;
        if (hz.pc_redirect_target !== 32'h200) begin
            errors++;
            $display("FAIL defer_target got=%h exp=%h", hz.pc_redirect_target, 32'h200);
        end
        tick();
        idle_inputs();
        hz.redirect_target_ex = 32'h444;
        #1;
        checks++;
        if (ctl !== C_NONE || hz.pc_redirect_target !== 32'h444) begin
            errors++;
            $display("FAIL defer_back_run got=%b/%h exp=%b/%h", ctl, hz.pc_redirect_target, C_NONE, 32'h444);
        end
        tick();
    endtask

    task automatic test_kill_mem_freeze();
        idle_inputs();
        hz.redirect_ex        = 1'b1;
        hz.redirect_target_ex = 32'h280;
        hz.imem_ready         = 1'b0;
        tick();
        idle_inputs();
        hz.imem_ready   = 1'b0;
        hz.dmem_req_mem = 1'b1;
        #1;
        checks++;
        if (ctl !== C_FREEZE) begin
            errors++;
            $display("FAIL kill_freeze got=%b exp=%b", ctl, C_FREEZE);
        end
        tick();
        hz.dmem_req_mem = 1'b0;
        hz.imem_ready   = 1'b1;
        #1;
        checks++;
        if (ctl !== C_KDONE || hz.pc_redirect_target !== 32'h280) begin
            errors++;
            $display("FAIL kill_freeze_done got=%b/%h exp=%b/%h", ctl, hz.pc_redirect_target, C_KDONE, 32'h280);
        end
        tick();
    endtask

    task automatic test_data_wait();
        idle_inputs();
        hz.dmem_req_mem       = 1'b1;
        hz.redirect_ex        = 1'b1;
        hz.redirect_target_ex = 32'h300;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ctl !== C_FREEZE) begin
                errors++;
                $display("FAIL dwait_%0d got=%b exp=%b", i, ctl, C_FREEZE);
            end
            tick();
        end
        hz.dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== C_REDIR || hz.pc_redirect_target !== 32'h300) begin
            errors++;
            $display("FAIL dwait_release got=%b/%h exp=%b/%h", ctl, hz.pc_redirect_target, C_REDIR, 32'h300);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_in_kill();
        idle_inputs();
        hz.redirect_ex        = 1'b1;
        hz.redirect_target_ex = 32'h400;
        hz.imem_ready         = 1'b0;
        tick();
        hz.redirect_ex = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        // Back in RUN: an outstanding fetch is a plain fetch wait.
        checks++;
        if (ctl !== C_IFW) begin
            errors++;
            $display("FAIL rst_kill_ctl got=%b exp=%b", ctl, C_IFW);
        end
        hz.imem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== C_NONE || hz.perf_stall_cycles !== 32'd0 || hz.perf_flush_count !== 32'd0) begin
            errors++;
            $display("FAIL rst_kill_idle got=%b/%0d/%0d exp=%b/0/0", ctl, hz.perf_stall_cycles, hz.perf_flush_count, C_NONE);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        #1;
        checks++;
        if (ctl !== C_NONE) begin
            errors++;
            $display("FAIL rst_kill_no_redirect got=%b exp=%b", ctl, C_NONE);
        end
        tick();
    endtask

    task automatic test_perf();
        logic [31:0] exp_stall;
        logic [31:0] exp_flush;
`ifdef HAZARD_PERF_CNT_EN
        exp_stall = 32'd10;
        exp_flush = 32'd1;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        idle_inputs();
        do_reset();
        hz.imem_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        idle_inputs();
        hz.redirect_ex        = 1'b1;
        hz.redirect_target_ex = 32'h500;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hz.perf_stall_cycles !== exp_stall) begin
            errors++;
            $display("FAIL perf_stall got=%0d exp=%0d", hz.perf_stall_cycles, exp_stall);
        end
        checks++;
        if (hz.perf_flush_count !== exp_flush) begin
            errors++;
            $display("FAIL perf_flush got=%0d exp=%0d", hz.perf_flush_count, exp_flush);
        end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rstn   = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_deferred();
        test_kill_mem_freeze();
        test_data_wait();
        test_reset_in_kill();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
